// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART byte-stream program loader for instruction memory
module uart_prog_loader #(
   parameter int unsigned ADDR_W    = 10,
   parameter logic [31:0] END_WORD  = 32'h0000_0FFF,
   parameter int unsigned START_DLY = 16,
   parameter int unsigned TIMEOUT   = 1000
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              rx_err,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              ldr_ready,
   output logic              core_rst_l,
   output logic              ldr_done,
   output logic              ldr_ovf,
   output logic [ADDR_W:0]   word_cnt
);

   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [15:0]     LP_DLY_LAST  = 16'(START_DLY - 1);
   localparam logic [15:0]     LP_IDLE_LAST = 16'(TIMEOUT - 1);
   localparam logic [ADDR_W:0] LP_CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   state_t            r_state;
   state_t            w_state_nxt;
   logic [15:0]       r_dly_cnt;
   logic [15:0]       r_idle_cnt;
   logic [1:0]        r_byte_cnt;
   logic [23:0]       r_word;
   logic [ADDR_W:0]   r_word_cnt;
   logic [ADDR_W-1:0] r_imem_addr;
   logic [31:0]       r_imem_wdata;
   logic              r_imem_we;
   logic              r_ldr_ready;
   logic              r_core_rst_l;
   logic              r_ldr_done;
   logic              r_ldr_ovf;

   logic              w_accept;
   logic              w_take;
   logic              w_last_byte;
   logic              w_is_end;
   logic              w_mem_full;
   logic              w_idle_tick;
   logic [31:0]       w_full_word;

   // Bytes are only taken while loading; a framing error always beats a coincident byte.
   assign w_accept    = (r_state == ST_LOAD) || (r_state == ST_WRITE);
   assign w_take      = w_accept && rx_valid && !rx_err;
   assign w_full_word = {rx_data, r_word};
   assign w_last_byte = w_take && (r_byte_cnt == 2'd3);
   assign w_is_end    = (w_full_word == END_WORD);
   // The write in flight targets the last address, so memory is full once it retires.
   assign w_mem_full  = (r_state == ST_WRITE) && (r_word_cnt[ADDR_W-1:0] == '1);
   assign w_idle_tick = (r_state == ST_LOAD) && (r_byte_cnt != 2'd0) && !rx_valid;

   // State register.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) r_state <= ST_WAIT;
      else        r_state <= w_state_nxt;
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_WAIT:  if (r_dly_cnt == LP_DLY_LAST) w_state_nxt = ST_LOAD;
         ST_LOAD:  if (w_last_byte) w_state_nxt = w_is_end ? ST_DONE : ST_WRITE;
         ST_WRITE: w_state_nxt = w_mem_full ? ST_DONE : ST_LOAD;
         ST_DONE:  w_state_nxt = ST_DONE;
         default:  w_state_nxt = ST_WAIT;
      endcase
   end

   // Start-up delay counter, running only while waiting.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l)                 r_dly_cnt <= 16'd0;
      else if (r_state == ST_WAIT) r_dly_cnt <= r_dly_cnt + 16'd1;
   end

   // Little-endian word assembly with error and idle-timeout discard of partial words.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_byte_cnt <= 2'd0;
         r_word     <= 24'd0;
         r_idle_cnt <= 16'd0;
      end else if (w_accept && rx_err) begin
         r_byte_cnt <= 2'd0;
         r_idle_cnt <= 16'd0;
      end else if (w_take) begin
         case (r_byte_cnt)
            2'd0:    r_word[7:0]   <= rx_data;
            2'd1:    r_word[15:8]  <= rx_data;
            2'd2:    r_word[23:16] <= rx_data;
            default: r_word        <= r_word;
         endcase
         r_byte_cnt <= r_byte_cnt + 2'd1;
         r_idle_cnt <= 16'd0;
      end else if (rx_valid) begin
         r_idle_cnt <= 16'd0;
      end else if (w_idle_tick) begin
         if (r_idle_cnt == LP_IDLE_LAST) begin
            r_idle_cnt <= 16'd0;
            r_byte_cnt <= 2'd0;
         end else begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
         end
      end
   end

   // Capture the write address/data on the completing byte; they hold until the next word.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_imem_addr  <= '0;
         r_imem_wdata <= 32'd0;
      end else if (w_last_byte && !w_is_end) begin
         r_imem_addr  <= r_word_cnt[ADDR_W-1:0];
         r_imem_wdata <= w_full_word;
      end
   end

   // Word counter advances at the end of each write cycle.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l)                  r_word_cnt <= '0;
      else if (r_state == ST_WRITE) r_word_cnt <= r_word_cnt + LP_CNT_ONE;
   end

   // Status outputs registered from the next state so they never glitch.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_imem_we    <= 1'b0;
         r_ldr_ready  <= 1'b0;
         r_core_rst_l <= 1'b0;
         r_ldr_done   <= 1'b0;
         r_ldr_ovf    <= 1'b0;
      end else begin
         r_imem_we    <= (w_state_nxt == ST_WRITE);
         r_ldr_ready  <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_WRITE);
         r_core_rst_l <= (w_state_nxt == ST_DONE);
         r_ldr_done   <= (w_state_nxt == ST_DONE);
         r_ldr_ovf    <= r_ldr_ovf | w_mem_full;
      end
   end

   assign imem_we    = r_imem_we;
   assign imem_addr  = r_imem_addr;
   assign imem_wdata = r_imem_wdata;
   assign ldr_ready  = r_ldr_ready;
   assign core_rst_l = r_core_rst_l;
   assign ldr_done   = r_ldr_done;
   assign ldr_ovf    = r_ldr_ovf;
   assign word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - self-checking bench for uart_prog_loader
module tb_uart_prog_loader;

   localparam int          ADDR_W   = 2;
   localparam logic [31:0] END_WORD = 32'h0000_0FFF;
   localparam int          TIMEOUT  = 1000;
   localparam int          NWORDS   = 1 << ADDR_W;

   logic              clk;
   logic              rst_l;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_err;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              ldr_ready;
   logic              core_rst_l;
   logic              ldr_done;
   logic              ldr_ovf;
   logic [ADDR_W:0]   word_cnt;

   int checks = 0;
   int errors = 0;

   logic [ADDR_W+31:0] got_q[$];
   logic [ADDR_W+31:0] exp_q[$];
   bit                 prev_we = 0;
   int                 dbl_we  = 0;

   // reference model: byte stream -> words -> memory writes
   int          m_cnt;
   int          m_nb;
   bit          m_done;
   bit          m_ovf;
   logic [31:0] m_acc;

   uart_prog_loader #(
      .ADDR_W(ADDR_W), .END_WORD(END_WORD), .START_DLY(16), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_l(rst_l), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .ldr_ready(ldr_ready), .core_rst_l(core_rst_l), .ldr_done(ldr_done),
      .ldr_ovf(ldr_ovf), .word_cnt(word_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // write monitor
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         if (prev_we) dbl_we = dbl_we + 1;
         got_q.push_back({imem_addr, imem_wdata});
      end
      prev_we = (imem_we === 1'b1);
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic model_clear();
      m_nb  = 0;
      m_acc = 32'd0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (m_done) return;
      m_acc = m_acc | ({24'd0, b} << (8 * m_nb));
      m_nb  = m_nb + 1;
      if (m_nb == 4) begin
         if (m_acc == END_WORD) begin
            m_done = 1;
         end else begin
            exp_q.push_back({ADDR_W'(m_cnt), m_acc});
            m_cnt = m_cnt + 1;
            if (m_cnt == NWORDS) begin
               m_done = 1;
               m_ovf  = 1;
            end
         end
         model_clear();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_l    = 1'b0;
      rx_valid = 1'b0;
      rx_err   = 1'b0;
      rx_data  = 8'd0;
      repeat (2) @(negedge clk);
      got_q.delete();
      exp_q.delete();
      m_cnt  = 0;
      m_done = 0;
      m_ovf  = 0;
      dbl_we = 0;
      model_clear();
      rst_l = 1'b1;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (ldr_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n = n + 1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_valid = 1'b1;
      rx_data  = b;
      model_byte(b);
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
      if (!m_done && m_nb != 0 && gap >= TIMEOUT) model_clear();
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
   endtask

   task automatic pulse_err(input bit with_valid, input int gap);
      rx_err   = 1'b1;
      rx_valid = with_valid;
      rx_data  = 8'($urandom);
      if (!m_done) model_clear();
      @(negedge clk);
      rx_err   = 1'b0;
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic test_reset();
      int n;
      rst_l = 1'b0; rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'd0;
      @(negedge clk);
      #1;
      checks++;
      if ({imem_we, imem_addr, imem_wdata, ldr_ready, core_rst_l, ldr_done, ldr_ovf, word_cnt} !== '0)
         begin errors++; $display("FAIL reset_outputs we=%b addr=%h wdata=%h rdy=%b crst=%b done=%b ovf=%b cnt=%0d want all 0",
                                  imem_we, imem_addr, imem_wdata, ldr_ready, core_rst_l, ldr_done, ldr_ovf, word_cnt); end
      do_reset();
      wait_ready(n);
      checks++;
      if (n != 16) begin errors++; $display("FAIL reset_ready_delay got %0d cycles want 16", n); end
      checks++;
      if (core_rst_l !== 1'b0 || ldr_done !== 1'b0)
         begin errors++; $display("FAIL reset_core_held core_rst_l=%b ldr_done=%b want 0 0", core_rst_l, ldr_done); end
   endtask

   task automatic test_basic();
      int n;
      logic [7:0] bytes [12] = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00,
                                 8'hFF, 8'h0F, 8'h00, 8'h00};
      do_reset();
      wait_ready(n);
      for (int i = 0; i < 12; i++) send_byte(bytes[i], 1);
      repeat (4) @(negedge clk);
      checks++;
      if (got_q.size() != 2 || got_q[0] !== {2'd0, 32'h0000_0513} || got_q[1] !== {2'd1, 32'h0010_0073})
         begin errors++; $display("FAIL basic_writes got %0d writes first=%h want 2 writes 0:00000513 1:00100073",
                                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 34'd0); end
      checks++;
      if ({ldr_done, core_rst_l, ldr_ovf, ldr_ready} !== 4'b1100 || word_cnt !== 3'd2)
         begin errors++; $display("FAIL basic_done done=%b crst=%b ovf=%b rdy=%b cnt=%0d want 1 1 0 0 cnt 2",
                                  ldr_done, core_rst_l, ldr_ovf, ldr_ready, word_cnt); end
      checks++;
      if (imem_addr !== 2'd1 || imem_wdata !== 32'h0010_0073)
         begin errors++; $display("FAIL basic_hold addr=%h wdata=%h want 1 00100073", imem_addr, imem_wdata); end
      send_word(32'h1234_5678, 0);
      repeat (3) @(negedge clk);
      checks++;
      if (got_q.size() != 2 || ldr_done !== 1'b1)
         begin errors++; $display("FAIL done_ignores_rx writes=%0d done=%b want 2 1", got_q.size(), ldr_done); end
      #2 rst_l = 1'b0;
      #1;
      checks++;
      if ({imem_we, imem_addr, imem_wdata, ldr_ready, core_rst_l, ldr_done, ldr_ovf, word_cnt} !== '0)
         begin errors++; $display("FAIL reset_from_done crst=%b done=%b cnt=%0d wdata=%h want all 0",
                                  core_rst_l, ldr_done, word_cnt, imem_wdata); end
   endtask

   task automatic test_rx_err();
      int n;
      do_reset();
      wait_ready(n);
      send_byte(8'h11, 1); send_byte(8'h22, 1);
      pulse_err(1'b0, 1);
      send_word(32'h1122_3344, 1);
      repeat (4) @(negedge clk);
      checks++;
      if (got_q.size() != 1 || got_q[0] !== {2'd0, 32'h1122_3344} || word_cnt !== 3'd1)
         begin errors++; $display("FAIL rx_err_discard writes=%0d cnt=%0d want 1 write 0:11223344",
                                  got_q.size(), word_cnt); end
      send_byte(8'hAA, 0);
      pulse_err(1'b1, 0);
      send_word(32'h0403_0201, 0);
      repeat (4) @(negedge clk);
      checks++;
      if (got_q.size() != 2 || got_q[1] !== {2'd1, 32'h0403_0201} || ldr_done !== 1'b0)
         begin errors++; $display("FAIL rx_err_with_valid writes=%0d done=%b want 2nd write 1:04030201",
                                  got_q.size(), ldr_done); end
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      wait_ready(n);
      send_byte(8'hAA, 0); send_byte(8'hBB, TIMEOUT);
      send_word(32'h0403_0201, 0);
      send_byte(8'h10, 0); send_byte(8'h20, TIMEOUT - 1);
      send_byte(8'h30, 0); send_byte(8'h40, 0);
      repeat (4) @(negedge clk);
      checks++;
      if (got_q.size() != 2 || got_q[0] !== {2'd0, 32'h0403_0201})
         begin errors++; $display("FAIL timeout_discard writes=%0d first=%h want 0:04030201",
                                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 34'd0); end
      checks++;
      if (got_q.size() != 2 || got_q[1] !== {2'd1, 32'h4030_2010})
         begin errors++; $display("FAIL timeout_minus1_keeps writes=%0d want 2nd write 1:40302010", got_q.size()); end
   endtask

   task automatic test_latency();
      int n;
      do_reset();
      wait_ready(n);
      send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0);
      rx_valid = 1'b1;
      rx_data  = 8'h12;
      @(negedge clk);
      rx_valid = 1'b0;
      checks++;
      if (imem_we !== 1'b1 || {imem_addr, imem_wdata} !== {2'd0, 32'h1234_5678})
         begin errors++; $display("FAIL write_latency we=%b addr=%h wdata=%h want 1 0 12345678",
                                  imem_we, imem_addr, imem_wdata); end
      checks++;
      if (ldr_ready !== 1'b1 || core_rst_l !== 1'b0)
         begin errors++; $display("FAIL write_state_flags rdy=%b crst=%b want 1 0", ldr_ready, core_rst_l); end
      @(negedge clk);
      checks++;
      if (imem_we !== 1'b0 || word_cnt !== 3'd1)
         begin errors++; $display("FAIL write_one_cycle we=%b cnt=%0d want 0 1", imem_we, word_cnt); end
   endtask

   task automatic test_overflow();
      int n;
      logic [31:0] w;
      do_reset();
      wait_ready(n);
      for (int i = 0; i < NWORDS + 1; i++) begin
         w = $urandom;
         if (w == END_WORD) w = ~w;
         send_word(w, $urandom_range(0, 2));
      end
      repeat (4) @(negedge clk);
      checks++;
      if (got_q.size() != NWORDS)
         begin errors++; $display("FAIL ovf_write_count got %0d want %0d", got_q.size(), NWORDS); end
      for (int i = 0; i < NWORDS && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i])
            begin errors++; $display("FAIL ovf_write[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
      end
      checks++;
      if ({ldr_ovf, ldr_done, core_rst_l, ldr_ready} !== 4'b1110 || word_cnt !== 3'd4)
         begin errors++; $display("FAIL ovf_flags ovf=%b done=%b crst=%b rdy=%b cnt=%0d want 1 1 1 0 cnt 4",
                                  ldr_ovf, ldr_done, core_rst_l, ldr_ready, word_cnt); end
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      wait_ready(n);
      send_word(32'hCAFE_0001, 0);
      send_byte(8'h01, 0); send_byte(8'h02, 0);
      #2 rst_l = 1'b0;
      #1;
      checks++;
      if ({imem_we, imem_addr, imem_wdata, ldr_ready, core_rst_l, ldr_done, ldr_ovf, word_cnt} !== '0)
         begin errors++; $display("FAIL mid_word_reset rdy=%b cnt=%0d wdata=%h want all 0",
                                  ldr_ready, word_cnt, imem_wdata); end
      do_reset();
      wait_ready(n);
      checks++;
      if (n != 16) begin errors++; $display("FAIL mid_reset_ready_delay got %0d want 16", n); end
      send_word(32'h0BAD_F00D, 1);
      repeat (4) @(negedge clk);
      checks++;
      if (got_q.size() != 1 || got_q[0] !== {2'd0, 32'h0BAD_F00D})
         begin errors++; $display("FAIL mid_reset_restart writes=%0d want 1 write 0:0badf00d", got_q.size()); end
      send_byte(8'h0A, 0); send_byte(8'h0B, 0); send_byte(8'h0C, 0);
      rx_valid = 1'b1;
      rx_data  = 8'h0D;
      @(posedge clk);
      #2;
      rx_valid = 1'b0;
      rst_l    = 1'b0;
      #1;
      checks++;
      if (imem_we !== 1'b0 || word_cnt !== 3'd0)
         begin errors++; $display("FAIL mid_write_reset we=%b cnt=%0d want 0 0", imem_we, word_cnt); end
      do_reset();
      wait_ready(n);
      send_word(32'h5555_AAAA, 0);
      repeat (4) @(negedge clk);
      checks++;
      if (got_q.size() != 1 || got_q[0] !== {2'd0, 32'h5555_AAAA})
         begin errors++; $display("FAIL mid_write_restart writes=%0d want 1 write 0:5555aaaa", got_q.size()); end
   endtask

   task automatic test_random();
      int n;
      int sel;
      int nb;
      for (int it = 0; it < 10; it++) begin
         do_reset();
         wait_ready(n);
         repeat ($urandom_range(1, 7)) begin
            sel = $urandom_range(0, 11);
            if (sel == 0) begin
               nb = $urandom_range(1, 3);
               for (int k = 0; k < nb; k++) send_byte(8'($urandom), $urandom_range(0, 2));
               pulse_err(1'($urandom_range(0, 1)), $urandom_range(0, 2));
            end else if (sel == 1) begin
               nb = $urandom_range(1, 3);
               for (int k = 0; k < nb - 1; k++) send_byte(8'($urandom), $urandom_range(0, 2));
               send_byte(8'($urandom), ($urandom_range(0, 1) == 1) ? TIMEOUT : TIMEOUT - 1);
            end else if (sel == 2) begin
               send_word(END_WORD, $urandom_range(0, 2));
            end else begin
               send_word($urandom, $urandom_range(0, 3));
            end
         end
         repeat (4) @(negedge clk);
         checks++;
         if (got_q.size() != exp_q.size())
            begin errors++; $display("FAIL rand_count it=%0d got %0d writes want %0d", it, got_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i])
               begin errors++; $display("FAIL rand_write it=%0d idx=%0d got %h want %h", it, i, got_q[i], exp_q[i]); end
         end
         checks++;
         if (word_cnt !== (ADDR_W+1)'(m_cnt) || ldr_done !== m_done || core_rst_l !== m_done ||
             ldr_ovf !== m_ovf || ldr_ready !== !m_done)
            begin errors++; $display("FAIL rand_status it=%0d cnt=%0d done=%b crst=%b ovf=%b rdy=%b want cnt=%0d done=%b ovf=%b",
                                     it, word_cnt, ldr_done, core_rst_l, ldr_ovf, ldr_ready, m_cnt, m_done, m_ovf); end
         checks++;
         if (dbl_we != 0) begin errors++; $display("FAIL rand_we_width it=%0d multi-cycle strobes %0d want 0", it, dbl_we); end
         if (exp_q.size() > 0) begin
            checks++;
            if ({imem_addr, imem_wdata} !== exp_q[exp_q.size() - 1])
               begin errors++; $display("FAIL rand_hold it=%0d got %h want %h", it, {imem_addr, imem_wdata},
                                        exp_q[exp_q.size() - 1]); end
         end
      end
   endtask

   initial begin
      rst_l = 1'b0; rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'd0;
      test_reset();
      test_basic();
      test_rx_err();
      test_timeout();
      test_latency();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction-memory word-address width (1024 words).
REQ-002 SHALL have parameter END_WORD, default 32'h0000_0FFF, end-of-program marker word.
REQ-003 SHALL have parameter START_DLY, default 16, cycles after reset release before ldr_ready asserts (1..65535).
REQ-004 SHALL have parameter TIMEOUT, default 1000, idle cycles after which a partial word is discarded (1..65535).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_l  input  1  reset, asynchronous, active-low.
REQ-007 rx_valid  input  1  one-cycle pulse, byte available from UART receiver.
REQ-008 rx_data  input  8  received byte, valid with rx_valid.
REQ-009 rx_err  input  1  one-cycle pulse, UART framing error.
REQ-010 imem_we  output  1  one-cycle instruction-memory write strobe.
REQ-011 imem_addr  output  ADDR_W  word address of write.
REQ-012 imem_wdata  output  32  write data.
REQ-013 ldr_ready  output  1  loader accepting program bytes (drives mprj_io[37]).
REQ-014 core_rst_l  output  1  active-low reset to the BrqRV core.
REQ-015 ldr_done  output  1  load finished, core running.
REQ-016 ldr_ovf  output  1  load ended by memory full, not END_WORD.
REQ-017 word_cnt  output  ADDR_W+1  number of words written.

Function
REQ-018 SHALL implement states WAIT, LOAD, WRITE, DONE; WAIT entered on reset.
REQ-019 WAIT: 16-bit delay counter counts clk cycles; after START_DLY cycles SHALL move to LOAD; rx_valid ignored in WAIT.
REQ-020 ldr_ready SHALL be 1 exactly in LOAD and WRITE, registered (no combinational path from inputs).
REQ-021 Bytes SHALL be assembled little-endian: 1st byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24]; 2-bit byte_cnt.
REQ-022 Bytes SHALL be accepted on rx_valid in LOAD and WRITE alike; no byte lost when arriving in the WRITE cycle.
REQ-023 On 4th byte, if assembled word == END_WORD SHALL go directly to DONE, no memory write, word_cnt unchanged.
REQ-024 Otherwise SHALL go to WRITE next cycle: imem_we=1 for exactly one cycle, imem_addr=word_cnt[ADDR_W-1:0], imem_wdata=assembled word; word_cnt increments at end of that cycle.
REQ-025 Write latency: imem_we SHALL assert the cycle after the rx_valid carrying the 4th byte.
REQ-026 imem_addr/imem_wdata SHALL hold last written values when imem_we=0.
REQ-027 After a write making word_cnt == 2**ADDR_W, SHALL go to DONE with ldr_ovf=1; further bytes ignored.
REQ-028 rx_err SHALL clear byte_cnt (discard partial word); written words and word_cnt unaffected; if rx_err and rx_valid coincide, rx_err wins and byte is dropped.
REQ-029 Idle counter SHALL count cycles in LOAD while byte_cnt != 0 and rx_valid=0; reset on any rx_valid; on reaching TIMEOUT SHALL clear byte_cnt and itself.
REQ-030 DONE: core_rst_l=1, ldr_done=1, ldr_ready=0, imem_we=0; all rx inputs ignored; held until rst_l asserted.
REQ-031 core_rst_l SHALL be 0 in WAIT, LOAD, WRITE, rising only on the DONE transition, glitch-free (registered).

Reset
REQ-032 rst_l=0 SHALL immediately force state=WAIT, core_rst_l=0 and all other outputs, counters, byte_cnt, assembly register to 0, regardless of current state.
REQ-033 Reset mid-word or mid-WRITE SHALL abort without further imem_we; next load restarts at address 0.

Verification
REQ-034 Reset release, no bytes -> ldr_ready rises after 16 cycles; core_rst_l=0, ldr_done=0.
REQ-035 Bytes 13,05,00,00, 73,00,10,00, FF,0F,00,00 -> writes (0,0x00000513),(1,0x00100073); ldr_done=1, core_rst_l=1, word_cnt=2, ldr_ovf=0.
REQ-036 Bytes 11,22, rx_err, then 44,33,22,11 -> single write addr 0 data 0x11223344.
REQ-037 Bytes AA,BB then 1000 idle cycles, then 01,02,03,04 -> single write addr 0 data 0x04030201.
REQ-038 ADDR_W=2, send 4 non-END words -> writes addr 0..3, then DONE with ldr_ovf=1, word_cnt=4; 5th word produces no write.
REQ-039 rst_l pulsed low after 2 bytes of word 1 (word 0 written) -> outputs zero, ldr_ready again after 16 cycles, next word writes addr 0.
